if_fetch_unit: RTL and testbench

//  Instruction-fetch front end of the RISC-V core. Generates sequential PCs, issues

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/if_fifo.sv | 72 +++++++
 rtl/if_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared types and constants for the fetch front end: data width, default
//   reset PC, the {pc,instr} buffer entry, the canonical NOP, and the fetch
//   FSM state encoding.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo
//   Synchronous FIFO with push, pop and flush. The head entry is read
//   combinationally from storage. Flush overrides a same-cycle push/pop.
//   Simultaneous push and pop on a full FIFO is allowed (count unchanged).
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Pointer and occupancy next-state; flush discards everything in flight.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because the head is qualified by count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end: sequential PC generation, credit-limited
//   requests to instruction memory, a PC queue for in-flight requests, an
//   instruction buffer toward decode, and redirect flushing with a drop
//   counter for stale responses.
//   Optional: define IF_FETCH_CNT_EN to add fetch_cnt / flush_cnt outputs.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0]     ibuf_count;
  logic [CW-1:0]     pcq_count;
  logic [CW-1:0]     outstanding;
  logic [2*XLEN-1:0] ibuf_head;
  logic [XLEN-1:0]   pcq_head;
  logic              accept;
  logic              rsp_fire;
  logic              rsp_keep;
  logic              ibuf_pop;
  logic              unused_redirect_lsb;

  // Every in-flight request is either still owed a buffer slot (PC queue) or
  // is stale and will be discarded (drop), so the sum is the outstanding count.
  assign outstanding = drop_q + pcq_count;

  // Credit rule: never request more than the buffer can absorb.
  assign imem_req_valid = (state_q == ST_FETCH) &&
                          (({1'b0, ibuf_count} + {1'b0, outstanding}) < CREDIT_LIMIT);
  assign imem_req_addr  = pc_q;

  assign accept   = imem_req_valid & imem_req_ready;
  // Responses with nothing outstanding (e.g. late ones after reset) are ignored.
  assign rsp_fire = imem_rsp_valid & (outstanding != '0);
  assign rsp_keep = rsp_fire & (drop_q == '0);

  assign id_valid = (ibuf_count != '0);
  assign ibuf_pop = id_valid & id_ready;
  assign id_pc    = id_valid ? ibuf_head[2*XLEN-1:XLEN] : '0;
  assign id_instr = id_valid ? ibuf_head[XLEN-1:0]      : '0;

  // Fetch addresses are always word aligned.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Boot lasts exactly one cycle after reset release, then fetch forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
    endcase
  end

  // PC and drop-counter next state; redirect has highest priority.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = outstanding + CW'(accept) - CW'(rsp_fire);
    end else begin
      if (accept) pc_d = pc_q + XLEN'(4);
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  // State, PC and drop registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // PC of each live request, in issue order.
  if_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk         (clk),
    .rst_n       (rst),
    .flush_i     (redirect_valid),
    .push_i      (accept),
    .push_data_i (pc_q),
    .pop_i       (rsp_keep),
    .head_o      (pcq_head),
    .count_o     (pcq_count)
  );

  // {pc,instr} entries waiting for decode.
  if_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk         (clk),
    .rst_n       (rst),
    .flush_i     (redirect_valid),
    .push_i      (rsp_keep),
    .push_data_i ({pcq_head, imem_rsp_data}),
    .pop_i       (ibuf_pop),
    .head_o      (ibuf_head),
    .count_o     (ibuf_count)
  );

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  // Delivered-instruction and redirect counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ibuf_pop)       fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed phases plus randomized traffic for if_fetch_unit, checked against
//   a queue-based reference of the fetch stream and an in-order memory model.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  if_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  out_t         outq[$];   // requests accepted, awaiting response
  fetch_entry_t bufq[$];   // what decode should see, in order
  mem_t         memq[$];   // memory's pending responses
  logic [31:0]  m_pc;
  bit           m_boot;
  int unsigned  m_fetch_cnt, m_flush_cnt;

  int checks, errors, cyc;
  int p_ready, p_idready, p_redirect, lat_max;
  bit f_redirect, f_late;
  logic [31:0] f_redirect_pc;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  function automatic bit m_req_valid();
    return !m_boot && ((bufq.size() + outq.size()) < DEPTH);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
  endtask

  task automatic model_reset();
    outq.delete();
    bufq.delete();
    m_pc        = RPC;
    m_boot      = 1'b1;
    m_fetch_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_id_valid"},  {31'd0, id_valid},       32'd0);
    chk({tag, "_id_pc"},     id_pc,                   32'd0);
    chk({tag, "_id_instr"},  id_instr,                32'd0);
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cycle();
    bit          exp_rv, exp_idv, acc, rsp, pop, rd, mem_del;
    logic [31:0] rpc;
    out_t        o;
    int          due;

    exp_rv  = m_req_valid();
    exp_idv = (bufq.size() > 0);

    imem_req_ready = ($urandom_range(99) < p_ready);
    id_ready       = ($urandom_range(99) < p_idready);
    rd  = f_redirect || ($urandom_range(999) < p_redirect);
    rpc = f_redirect ? f_redirect_pc :
          (($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
    redirect_valid = rd;
    redirect_pc    = rpc;
    mem_del = 1'b0;
    if (f_late) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      mem_del        = 1'b1;
    end else if (outq.size() == 0 && memq.size() == 0 && $urandom_range(9) == 0) begin
      imem_rsp_valid = 1'b1;   // stray response with nothing outstanding
      imem_rsp_data  = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end

    #1;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, exp_idv});
    chk("id_pc",    id_pc,    exp_idv ? bufq[0].pc    : 32'd0);
    chk("id_instr", id_instr, exp_idv ? bufq[0].instr : 32'd0);

    acc = exp_rv && imem_req_ready;
    rsp = imem_rsp_valid && (outq.size() > 0);
    pop = exp_idv && id_ready;

    if (pop) begin
      void'(bufq.pop_front());
      m_fetch_cnt++;
    end
    if (mem_del) void'(memq.pop_front());
    if (rsp) begin
      o = outq.pop_front();
      if (!o.stale) bufq.push_back('{pc: o.pc, instr: imem_rsp_data});
    end
    if (acc) begin
      outq.push_back('{pc: m_pc, stale: 1'b0});
      due = cyc + int'($urandom_range(lat_max, 1));
      if (memq.size() > 0 && due <= memq[$].due) due = memq[$].due + 1;
      memq.push_back('{addr: m_pc, due: due});
    end
    if (rd) begin
      bufq.delete();
      foreach (outq[i]) outq[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
      m_flush_cnt++;
    end else if (acc) begin
      m_pc = m_pc + 32'd4;
    end
    m_boot = 1'b0;
    if (f_late) begin
      memq.delete();
      f_late = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int n;
    bit found;
    checks = 0; errors = 0; cyc = 0;
    f_redirect = 1'b0; f_late = 1'b0; f_redirect_pc = '0;
    p_ready = 100; p_idready = 100; p_redirect = 0; lat_max = 1;
    drive_idle();
    model_reset();
    memq.delete();

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    // 1: streaming with a one-cycle memory
    repeat (20) cycle();

    // 2: decode stalled -> credit limit stops requests, then drain in order
    p_idready = 0;
    repeat (20) cycle();
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_id_valid",  {31'd0, id_valid},       32'd1);
    p_idready = 100;
    repeat (20) cycle();

    // 3: redirect with two requests in flight
    lat_max = 3;
    n = 0;
    while (outq.size() != 2 && n < 50) begin cycle(); n++; end
    f_redirect = 1'b1; f_redirect_pc = 32'h0000_0100;
    cycle();
    f_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (id_valid) found = 1'b1;
      else cycle();
    end
    chk("t3_delivered", {31'd0, found}, 32'd1);
    if (found) chk("t3_first_pc", id_pc, 32'h0000_0100);

    // 4: unaligned redirect in the same cycle as a request accept
    n = 0;
    while (!m_req_valid() && n < 20) begin cycle(); n++; end
    f_redirect = 1'b1; f_redirect_pc = 32'h0000_0203;
    cycle();
    f_redirect = 1'b0;
    chk("t4_addr_align", imem_req_addr, 32'h0000_0200);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (id_valid) found = 1'b1;
      else cycle();
    end
    chk("t4_delivered", {31'd0, found}, 32'd1);
    if (found) chk("t4_first_pc", id_pc, 32'h0000_0200);

    // 5: memory backpressure toggling
    lat_max = 2; p_ready = 50;
    repeat (60) cycle();

    // 6: reset mid-stream with a response pending
    p_ready = 100; lat_max = 3;
    n = 0;
    while (outq.size() == 0 && n < 30) begin cycle(); n++; end
    drive_idle();
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("midrst_hold");
    model_reset();
    f_late = 1'b1;
    rst = 1'b1;
    cycle();
    chk("t6_refetch_addr", imem_req_addr, RPC);
    repeat (20) cycle();

    // 7: fully randomized traffic
    p_ready = 70; p_idready = 70; p_redirect = 30; lat_max = 3;
    repeat (3000) cycle();
    p_redirect = 0; p_ready = 100; p_idready = 100;
    repeat (20) cycle();

`ifdef IF_FETCH_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetch_cnt);
    chk("flush_cnt", flush_cnt, m_flush_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
